// File: rtl/cache_flush_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_flush_seq_if
// Description : MMIO register bus plus the per-cache flush handshake and way
//               masks that connect cache_flush_seq to its bus master and caches.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_flush_seq_if #(
  parameter int N_CACHES = 2,
  parameter int MAX_WAYS = 8
);

  // MMIO register access
  logic                         wr_en;
  logic [3:0]                   wr_sel;
  logic [31:0]                  wr_data;
  logic [3:0]                   rd_sel;
  logic [31:0]                  rd_data;

  // Cache-side handshake and way-enable masks
  logic [N_CACHES-1:0]          flush_req;
  logic [N_CACHES-1:0]          flush_ack;
  logic [N_CACHES*MAX_WAYS-1:0] way_mask;

  // Bus master / cache side: drives writes, reads and acks
  modport master (
    output wr_en, wr_sel, wr_data, rd_sel, flush_ack,
    input  rd_data, flush_req, way_mask
  );

  // Controller side
  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel, flush_ack,
    output rd_data, flush_req, way_mask
  );

endinterface
`default_nettype wire

// File: rtl/cache_flush_seq.sv
`default_nettype none
// ============================================================================
// Module      : cache_flush_seq
// Description : Cache security controller. Holds per-cache way masks, sticky
//               flush-policy bits, and sequences coalesced flush rounds with a
//               per-cache req/ack handshake and a per-round timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_flush_seq #(
  parameter int N_CACHES  = 2,
  parameter int MAX_WAYS  = 8,
  parameter int TIMEOUT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              asid_change_pulse,
  input  logic              sfence_global,
  input  logic              lock_i,
  output logic              flush_busy,
  output logic              flush_done,
  cache_flush_seq_if.slave  bus
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [N_CACHES-1:0]   req_q, req_d;
  logic [N_CACHES-1:0]   active_q, active_d;
  logic [N_CACHES-1:0]   pend_q, pend_d;
  logic [N_CACHES-1:0]   tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

  logic                  pol_asid_q;
  logic                  pol_sfence_q;
  logic [MAX_WAYS-1:0]   mask_q [N_CACHES];

  logic                  ctrl_wr;
  logic                  stat_wr;
  logic [N_CACHES-1:0]   force_vec;
  logic [N_CACHES-1:0]   tmo_clr;
  logic [N_CACHES-1:0]   new_ev;
  logic [N_CACHES-1:0]   ack_hit;
  logic [N_CACHES-1:0]   load_set;
  logic [31:0]           rd_mux;
  logic                  unused_wr_bits;

  // --------------------------------------------------------------------------
  // Write decode and event collection
  // --------------------------------------------------------------------------
  assign ctrl_wr   = bus.wr_en && (bus.wr_sel == 4'd0);
  assign stat_wr   = bus.wr_en && (bus.wr_sel == 4'd1);
  assign force_vec = ctrl_wr ? bus.wr_data[N_CACHES-1:0] : '0;
  assign tmo_clr   = stat_wr ? bus.wr_data[N_CACHES-1:0] : '0;

  // Context events hit every cache; forced flushes hit only the written bits.
  assign new_ev = force_vec
                | {N_CACHES{pol_asid_q & asid_change_pulse}}
                | {N_CACHES{pol_sfence_q & sfence_global}};

  // Only acks that match an outstanding request count.
  assign ack_hit  = bus.flush_ack & req_q;
  assign load_set = pend_q | new_ev;

  // Not every write-data bit maps to a register field.
  assign unused_wr_bits = ^bus.wr_data;

  // --------------------------------------------------------------------------
  // Sticky policy bits: can only be set, and only while unlocked
  // --------------------------------------------------------------------------
  // Policy registers set by write-1 when the config lock is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_asid_q   <= 1'b1;
      pol_sfence_q <= 1'b1;
    end else if (ctrl_wr && !lock_i) begin
      pol_asid_q   <= pol_asid_q   | bus.wr_data[31];
      pol_sfence_q <= pol_sfence_q | bus.wr_data[30];
    end
  end

  // --------------------------------------------------------------------------
  // Way masks: independent of the flush FSM; zero masks are never accepted
  // so a cache always keeps at least one enabled way.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CACHES; gi++) begin : g_way
    // Per-cache mask register updated by an accepted unlocked nonzero write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mask_q[gi] <= '1;
      end else if (bus.wr_en && (bus.wr_sel == 4'(gi + 2)) && !lock_i &&
                   (bus.wr_data[MAX_WAYS-1:0] != '0)) begin
        mask_q[gi] <= bus.wr_data[MAX_WAYS-1:0];
      end
    end
    assign bus.way_mask[gi*MAX_WAYS +: MAX_WAYS] = mask_q[gi];
  end

  // --------------------------------------------------------------------------
  // Flush sequencer
  // --------------------------------------------------------------------------
  // State and round datapath registers; async reset drops flush_req at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      active_q <= '0;
      pend_q   <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-datapath logic for the flush round
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    active_d = active_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    // Software clear first so a timeout in the same cycle still sticks.
    tmo_d    = tmo_q & ~tmo_clr;

    case (state_q)
      S_IDLE, S_DONE: begin
        active_d = '0;
        if (load_set != '0) begin
          // Start a round with everything pending plus this cycle's events.
          state_d  = S_FLUSH;
          active_d = load_set;
          req_d    = load_set;
          pend_d   = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_FLUSH: begin
        // Events during a round are deferred to the next round.
        pend_d = pend_q | new_ev;
        cnt_d  = cnt_q + CNT_ONE;
        req_d  = req_q & ~ack_hit;
        if (req_q == '0) begin
          state_d  = S_DONE;
          active_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          // An ack arriving on the abort cycle still counts as completion.
          tmo_d    = tmo_d | (req_q & ~ack_hit);
          req_d    = '0;
          state_d  = S_DONE;
          active_d = '0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        req_d    = '0;
        active_d = '0;
      end
    endcase
  end

  assign bus.flush_req = req_q;
  assign flush_done    = (state_q == S_DONE);
  assign flush_busy    = (state_q != S_IDLE) || (pend_q != '0);

  // --------------------------------------------------------------------------
  // Register read mux
  // --------------------------------------------------------------------------
  // Combinational read data; unmapped selects read as zero
  always_comb begin
    rd_mux = '0;
    case (bus.rd_sel)
      4'd0: rd_mux = {pol_asid_q, pol_sfence_q, lock_i, 29'b0};
      4'd1: rd_mux = {flush_busy, 7'b0, 8'(active_q), 8'(pend_q), 8'(tmo_q)};
      default: begin
        for (int i = 0; i < N_CACHES; i++) begin
          if (bus.rd_sel == 4'(i + 2)) begin
            rd_mux = 32'(mask_q[i]);
          end
        end
      end
    endcase
  end

  assign bus.rd_data = rd_mux;

endmodule
`default_nettype wire
